// File: rtl/mips_bus_pkg.sv
// Shared address map, register offsets and STATUS layout for the data-bus responder.
package mips_bus_pkg;

    localparam logic [27:0] IO_PAGE  = 28'hFFFF000;
    localparam logic [15:0] RAM_PAGE = 16'h0000;

    // Word offsets within the IO page (addr[3:2]).
    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_TIMER  = 2'd2,
        REG_CTRL   = 2'd3
    } io_reg_e;

    // STATUS bit positions.
    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

    // CTRL bit positions.
    localparam int unsigned CTRL_OVF_CLR = 0;
    localparam int unsigned CTRL_TEN     = 1;

    function automatic logic [31:0] pack_status(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] s;
        s                          = '0;
        s[ST_COUNT_LSB+7:ST_COUNT_LSB] = count;
        s[ST_OVF]                  = ovf;
        s[ST_FULL]                 = full;
        s[ST_EMPTY]                = empty;
        return s;
    endfunction

endpackage

// File: rtl/mips_dbus_responder_byte_fifo.sv
// Byte FIFO with wrap-around pointers; head is visible combinationally on dout.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             pop_eff;
    logic             push_eff;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Pop only when data is present; a push into a full FIFO lands only if a pop frees the slot.
    always_comb begin
        pop_eff  = pop & ~empty;
        push_eff = push & (~full | pop_eff);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset because dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mips_dbus_responder.sv
// Data-bus responder: word RAM plus an IO page (TX FIFO, status, timer, control).
module mips_dbus_responder
    import mips_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic              ram_hit;
    logic              io_hit;
    io_reg_e           io_reg;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_q [RAM_WORDS];

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [15:0]       count_ext;
    logic              drop;

    logic              ten_q,   ten_d;
    logic              ovf_q,   ovf_d;
    logic [31:0]       timer_q, timer_d;
    logic              unused_addr;

    assign ram_hit     = (addr[31:16] == RAM_PAGE);
    assign io_hit      = (addr[31:4] == IO_PAGE);
    assign io_reg      = io_reg_e'(addr[3:2]);
    assign ram_idx     = addr[RAM_AW+1:2];
    assign unused_addr = ^addr;

    assign fifo_push = memwrite & io_hit & (io_reg == REG_TXDATA);
    assign fifo_pop  = tx_valid & tx_ready;
    assign tx_valid  = ~fifo_empty;
    assign drop      = fifo_push & fifo_full & ~fifo_pop;
    assign count_ext = 16'(fifo_count);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (writedata[7:0]),
        .pop   (fifo_pop),
        .dout  (tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Word RAM: synchronous write, combinational read, no reset.
    always_ff @(posedge clk) begin
        if (memwrite && ram_hit) ram_q[ram_idx] <= writedata;
    end

    // Next-state for timer, timer enable and sticky overflow.
    always_comb begin
        ten_d   = ten_q;
        ovf_d   = ovf_q;
        timer_d = ten_q ? timer_q + 32'd1 : timer_q;
        if (memwrite && io_hit && io_reg == REG_TIMER) timer_d = writedata;
        if (memwrite && io_hit && io_reg == REG_CTRL) begin
            ten_d = writedata[CTRL_TEN];
            if (writedata[CTRL_OVF_CLR]) ovf_d = 1'b0;
        end
        // A dropped push overrides a same-cycle clear.
        if (drop) ovf_d = 1'b1;
    end

    // Control/timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ten_q   <= 1'b1;
            ovf_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            ten_q   <= ten_d;
            ovf_q   <= ovf_d;
            timer_q <= timer_d;
        end
    end

    // Load data mux.
    always_comb begin
        readdata = '0;
        if (ram_hit) begin
            readdata = ram_q[ram_idx];
        end else if (io_hit) begin
            case (io_reg)
                REG_TXDATA: readdata = '0;
                REG_STATUS: readdata = pack_status(count_ext[7:0], ovf_q, fifo_full, fifo_empty);
                REG_TIMER:  readdata = timer_q;
                REG_CTRL: begin
                    readdata           = '0;
                    readdata[CTRL_TEN] = ten_q;
                end
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dbus_responder.sv
// Directed-vector bench for mips_dbus_responder.
module tb_mips_dbus_responder;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_TM  = 32'hFFFF_0008;
    localparam logic [31:0] A_CT  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_v;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs[$];
    int   split;

    mips_dbus_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .memwrite  (memwrite),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                input logic rdy, input logic chk, input logic [31:0] rd,
                                input logic v, input logic [7:0] d);
        vec_t t;
        t.addr = a; t.we = we; t.wd = wd; t.rdy = rdy;
        t.chk_rd = chk; t.exp_rd = rd; t.exp_v = v; t.exp_d = d;
        return t;
    endfunction

    function automatic logic [7:0] drain_byte(input int k);
        return (k < 7) ? 8'(8'h11 + k) : 8'h19;
    endfunction

    // One cycle: drive at the falling edge, check pre-edge outputs, commit at the next rising edge.
    task automatic apply_vec(input vec_t t, input int idx);
        @(negedge clk);
        addr = t.addr; memwrite = t.we; writedata = t.wd; tx_ready = t.rdy;
        #1;
        if (t.chk_rd) check($sformatf("v%0d readdata", idx), readdata, t.exp_rd);
        check($sformatf("v%0d tx_valid", idx), 32'(tx_valid), 32'(t.exp_v));
        check($sformatf("v%0d tx_data", idx), 32'(tx_data), 32'(t.exp_d));
    endtask

    initial begin
        // Test 1: RAM store/load and unmapped read
        vecs.push_back(mk(32'h0000_0010, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0010, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(32'h0001_0000, 0, 0, 0, 1, 32'h0, 0, 0));
        // Test 2: FIFO order
        vecs.push_back(mk(A_TX, 1, 32'h41, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(A_TX, 1, 32'h42, 0, 1, 0, 1, 8'h41));
        vecs.push_back(mk(A_TX, 1, 32'h43, 0, 1, 0, 1, 8'h41));
        vecs.push_back(mk(A_ST, 0, 0, 0, 1, 32'h300, 1, 8'h41));
        vecs.push_back(mk(A_ST, 0, 0, 1, 1, 32'h300, 1, 8'h41));
        vecs.push_back(mk(A_ST, 0, 0, 1, 1, 32'h200, 1, 8'h42));
        vecs.push_back(mk(A_ST, 0, 0, 1, 1, 32'h100, 1, 8'h43));
        vecs.push_back(mk(A_ST, 0, 0, 0, 1, 32'h001, 0, 8'h00));
        // Test 3: overflow (9th push dropped), push+pop when full, ovf clear, drain
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(A_TX, 1, 32'(8'h10 + i), 0, 1, 0, i > 0, (i > 0) ? 8'h10 : 8'h00));
        vecs.push_back(mk(A_ST, 0, 0, 0, 1, 32'h806, 1, 8'h10));
        vecs.push_back(mk(A_TX, 1, 32'h19, 1, 1, 0, 1, 8'h10));
        vecs.push_back(mk(A_ST, 0, 0, 0, 1, 32'h806, 1, 8'h11));
        vecs.push_back(mk(A_CT, 1, 32'h3, 0, 1, 32'h2, 1, 8'h11));
        vecs.push_back(mk(A_ST, 0, 0, 0, 1, 32'h802, 1, 8'h11));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(A_ST, 0, 0, 1, 1, (32'(8 - k) << 8) | ((k == 0) ? 32'h2 : 32'h0),
                              1, drain_byte(k)));
        vecs.push_back(mk(A_ST, 0, 0, 0, 1, 32'h1, 0, 8'h00));
        // Test 4: timer wrap, freeze, load-over-increment
        vecs.push_back(mk(A_TM, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(A_CT, 1, 32'h0, 0, 1, 32'h2, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'h2, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'h2, 0, 0));
        vecs.push_back(mk(A_TM, 1, 32'h1234, 0, 1, 32'h2, 0, 0));
        vecs.push_back(mk(A_CT, 1, 32'h2, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(A_TM, 1, 32'hABCD, 0, 1, 32'h1234, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'hABCD, 0, 0));
        vecs.push_back(mk(A_TM, 0, 0, 0, 1, 32'hABCE, 0, 0));
        split = vecs.size();
        // Test 6: unmapped writes, aliasing, misaligned loads (run after the reset test)
        vecs.push_back(mk(32'h0000_0000, 1, 32'h1111_1111, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h8000_0000, 1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'h8000_0000, 1, 32'h41, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 32'h1111_1111, 0, 0));
        vecs.push_back(mk(32'h0000_0010, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(32'hFFFF_0006, 0, 0, 0, 1, 32'h1, 0, 0));
        vecs.push_back(mk(32'h0000_0104, 1, 32'hCAFE_F00D, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0004, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0));
        vecs.push_back(mk(32'h0000_0013, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(32'hFFFF_0010, 0, 0, 0, 1, 32'h0, 0, 0));

        // Power-on reset
        reset = 1'b0; addr = '0; memwrite = 1'b0; writedata = '0; tx_ready = 1'b0;
        #1;
        check("reset tx_valid", 32'(tx_valid), 32'h0);
        check("reset tx_data", 32'(tx_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        addr = A_CT;
        #1;
        check("reset ctrl", readdata, 32'h2);

        for (int i = 0; i < split; i++) apply_vec(vecs[i], i);

        // Test 5: asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++)
            apply_vec(mk(A_TX, 1, 32'(8'h60 + i), 0, 1, 0, i > 0, (i > 0) ? 8'h60 : 8'h00), 100 + i);
        @(negedge clk);
        addr = A_ST; memwrite = 1'b0; tx_ready = 1'b1;
        #1;
        check("pre-reset status", readdata, 32'h400);
        @(posedge clk);
        #2;
        check("mid-drain tx_valid", 32'(tx_valid), 32'h1);
        check("mid-drain tx_data", 32'(tx_data), 32'h61);
        reset = 1'b0;
        #1;
        check("async reset tx_valid", 32'(tx_valid), 32'h0);
        check("async reset tx_data", 32'(tx_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        addr = A_TM;
        reset = 1'b1;
        #1;
        check("post-reset timer", readdata, 32'h0);
        addr = A_ST;
        #1;
        check("post-reset status", readdata, 32'h1);
        addr = A_CT;
        #1;
        check("post-reset ctrl", readdata, 32'h2);
        addr = 32'h0000_0010;
        #1;
        check("post-reset ram", readdata, 32'hDEAD_BEEF);

        for (int i = split; i < vecs.size(); i++) apply_vec(vecs[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
